// File: rtl/stepgen_cmd_sched.sv
// Stages SPI velocity bytes in shadow registers, validates each frame and commits all four velocities at once; owns the command watchdog and the safe-stop ramp.
// Latency: commit, pulses, watchdog and ramp updates take effect on the edge that samples the event; every output is registered.
// Backpressure: none; a byte is accepted every cycle and ticks are never deferred.
module stepgen_cmd_sched #(
  parameter int         F         = 11,
  parameter int         WDT_W     = 8,
  parameter int         WDT_LIMIT = 200,
  parameter logic [F:0] RAMP      = (F+1)'(16)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         frame_start,
  input  logic         frame_end,
  input  logic         byte_valid,
  input  logic [4:0]   byte_addr,
  input  logic [7:0]   byte_data,
  input  logic         tick,
  output logic [F:0]   vel0,
  output logic [F:0]   vel1,
  output logic [F:0]   vel2,
  output logic [F:0]   vel3,
  output logic         frame_ok,
  output logic         frame_err,
  output logic         safe_stop,
  output logic [7:0]   err_count
);

  typedef logic [F:0] vel_t;

  // Capture state for the frame currently being received.
  vel_t       shadow_q [4];
  vel_t       shadow_d [4];
  logic [7:0] xor_q, xor_d;
  logic [3:0] exp_q, exp_d;
  logic       bad_q, bad_d;

  // Committed / watchdog state.
  vel_t             vel_q [4];
  vel_t             vel_d [4];
  logic [WDT_W-1:0] wdt_q, wdt_d;
  logic             safe_q, safe_d;
  logic [1:0]       p_q, p_d;
  logic             ok_q, ok_d;
  logic             err_q, err_d;
  logic [7:0]       errcnt_q, errcnt_d;

  logic             commit;

  // One ramp step toward zero; magnitude is taken one bit wider so -2^F does not overflow.
  function automatic vel_t ramp_step(input vel_t v);
    logic [F+1:0] mag;
    vel_t         r;
    mag = v[F] ? -{v[F], v} : {1'b0, v};
    if (mag <= {1'b0, RAMP}) begin
      r = '0;
    end else if (!v[F]) begin
      r = v - RAMP;
    end else begin
      r = v + RAMP;
    end
    return r;
  endfunction

  // Byte capture: a frame_start clears first, so a coincident byte lands as the first byte.
  always_comb begin
    shadow_d = shadow_q;
    xor_d    = xor_q;
    exp_d    = exp_q;
    bad_d    = bad_q;
    if (frame_start) begin
      xor_d = '0;
      exp_d = '0;
      bad_d = 1'b0;
    end
    if (byte_valid && (byte_addr < 5'd9)) begin
      if (byte_addr != {1'b0, exp_d}) begin
        bad_d = 1'b1;
      end else begin
        exp_d = exp_d + 4'd1;
      end
      if (byte_addr < 5'd8) begin
        xor_d = xor_d ^ byte_data;
        if (byte_addr[0]) begin
          shadow_d[byte_addr[2:1]][F:8] = byte_data[F-8:0];
        end else begin
          shadow_d[byte_addr[2:1]][7:0] = byte_data;
        end
      end else if (byte_data != (xor_d ^ 8'hA5)) begin
        bad_d = 1'b1;
      end
    end
  end

  // Frame judgement uses the capture state as it stood before this cycle's byte.
  assign commit = frame_end && (exp_q == 4'd9) && !bad_q;

  // Commit, watchdog and ramp; a commit suppresses a coincident tick entirely.
  always_comb begin
    vel_d    = vel_q;
    wdt_d    = wdt_q;
    safe_d   = safe_q;
    p_d      = p_q;
    ok_d     = 1'b0;
    err_d    = 1'b0;
    errcnt_d = errcnt_q;
    if (frame_end) begin
      if (commit) begin
        vel_d  = shadow_q;
        ok_d   = 1'b1;
        wdt_d  = '0;
        safe_d = 1'b0;
      end else begin
        err_d = 1'b1;
        if (errcnt_q != 8'hFF) begin
          errcnt_d = errcnt_q + 8'd1;
        end
      end
    end
    if (tick && !commit) begin
      if (!safe_q) begin
        if (wdt_q == WDT_W'(WDT_LIMIT - 1)) begin
          safe_d = 1'b1;
        end else begin
          wdt_d = wdt_q + 1'b1;
        end
      end else begin
        vel_d[p_q] = ramp_step(vel_q[p_q]);
        p_d        = p_q + 2'd1;
      end
    end
  end

  // State registers; reset leaves the block in safe-stop with zero velocity.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        shadow_q[i] <= '0;
        vel_q[i]    <= '0;
      end
      xor_q    <= '0;
      exp_q    <= '0;
      bad_q    <= 1'b0;
      wdt_q    <= '0;
      safe_q   <= 1'b1;
      p_q      <= '0;
      ok_q     <= 1'b0;
      err_q    <= 1'b0;
      errcnt_q <= '0;
    end else begin
      shadow_q <= shadow_d;
      vel_q    <= vel_d;
      xor_q    <= xor_d;
      exp_q    <= exp_d;
      bad_q    <= bad_d;
      wdt_q    <= wdt_d;
      safe_q   <= safe_d;
      p_q      <= p_d;
      ok_q     <= ok_d;
      err_q    <= err_d;
      errcnt_q <= errcnt_d;
    end
  end

  assign vel0      = vel_q[0];
  assign vel1      = vel_q[1];
  assign vel2      = vel_q[2];
  assign vel3      = vel_q[3];
  assign frame_ok  = ok_q;
  assign frame_err = err_q;
  assign safe_stop = safe_q;
  assign err_count = errcnt_q;

endmodule

// File: tb/tb_stepgen_cmd_sched.sv
// Bench for stepgen_cmd_sched: directed steps then randomized frames, checked every cycle against a frame-level model.
// Inputs change on the falling edge; outputs are compared on the following falling edge.
// The model judges frames from the list of bytes seen since the last frame_start.
module tb_stepgen_cmd_sched;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        frame_start = 1'b0, frame_end = 1'b0, byte_valid = 1'b0, tick = 1'b0;
  logic [4:0]  byte_addr = '0;
  logic [7:0]  byte_data = '0;
  logic [11:0] vel0, vel1, vel2, vel3;
  logic        frame_ok, frame_err, safe_stop;
  logic [7:0]  err_count;

  int checks = 0;
  int errors = 0;

  stepgen_cmd_sched dut (
    .clk(clk), .rst(rst), .frame_start(frame_start), .frame_end(frame_end),
    .byte_valid(byte_valid), .byte_addr(byte_addr), .byte_data(byte_data), .tick(tick),
    .vel0(vel0), .vel1(vel1), .vel2(vel2), .vel3(vel3),
    .frame_ok(frame_ok), .frame_err(frame_err), .safe_stop(safe_stop), .err_count(err_count)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  int  sh_byte [8];
  int  mvel [4];
  int  q_addr [$];
  int  q_data [$];
  bit  msafe, mok, mferr;
  int  mticks, mp, merr;

  // Frame buffer used by the stimulus.
  int fa [16];
  int fd [16];
  int fn;

  function automatic void model_reset();
    for (int i = 0; i < 8; i++) sh_byte[i] = 0;
    for (int i = 0; i < 4; i++) mvel[i] = 0;
    q_addr.delete(); q_data.delete();
    msafe = 1; mok = 0; mferr = 0; mticks = 0; mp = 0; merr = 0;
  endfunction

  function automatic bit frame_valid();
    int x;
    if (q_addr.size() != 9) return 0;
    x = 0;
    for (int i = 0; i < 9; i++) if (q_addr[i] != i) return 0;
    for (int i = 0; i < 8; i++) x = x ^ q_data[i];
    return ((x ^ 'hA5) == q_data[8]);
  endfunction

  function automatic int vel_of(input int k);
    int v;
    v = ((sh_byte[2*k+1] & 15) << 8) | sh_byte[2*k];
    if (v >= 2048) v -= 4096;
    return v;
  endfunction

  function automatic int ramp(input int v);
    int a;
    a = (v < 0) ? -v : v;
    if (a <= 16) return 0;
    return (v > 0) ? v - 16 : v + 16;
  endfunction

  function automatic void model_step(input bit fs, fe, bv, input int a, d, input bit tk);
    bit c;
    c = 0; mok = 0; mferr = 0;
    if (fe) begin
      if (frame_valid()) begin
        for (int k = 0; k < 4; k++) mvel[k] = vel_of(k);
        mok = 1; mticks = 0; msafe = 0; c = 1;
      end else begin
        mferr = 1;
        if (merr < 255) merr++;
      end
    end
    if (tk && !c) begin
      if (!msafe) begin
        mticks++;
        if (mticks >= 200) msafe = 1;
      end else begin
        mvel[mp] = ramp(mvel[mp]);
        mp = (mp + 1) % 4;
      end
    end
    if (fs) begin q_addr.delete(); q_data.delete(); end
    if (bv && a < 9) begin
      q_addr.push_back(a); q_data.push_back(d);
      if (a < 8) sh_byte[a] = d;
    end
  endfunction

  // ---------------- checking ----------------
  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic compare_all();
    chk("vel0", int'($signed(vel0)), mvel[0]);
    chk("vel1", int'($signed(vel1)), mvel[1]);
    chk("vel2", int'($signed(vel2)), mvel[2]);
    chk("vel3", int'($signed(vel3)), mvel[3]);
    chk("frame_ok", int'(frame_ok), int'(mok));
    chk("frame_err", int'(frame_err), int'(mferr));
    chk("safe_stop", int'(safe_stop), int'(msafe));
    chk("err_count", int'(err_count), merr);
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic step(input bit fs, fe, bv, input int a, d, input bit tk);
    frame_start = fs; frame_end = fe; byte_valid = bv;
    byte_addr = 5'(a); byte_data = 8'(d); tick = tk;
    @(posedge clk);
    model_step(fs, fe, bv, a, d, tk);
    @(negedge clk);
    frame_start = 0; frame_end = 0; byte_valid = 0; tick = 0;
    compare_all();
  endtask

  // Fill the frame buffer with a correctly ordered, correctly checksummed frame.
  task automatic build(input int v0, v1, v2, v3);
    int v [4];
    int x;
    v[0] = v0; v[1] = v1; v[2] = v2; v[3] = v3;
    x = 0;
    for (int k = 0; k < 4; k++) begin
      fa[2*k] = 2*k;     fd[2*k] = v[k] & 255;
      fa[2*k+1] = 2*k+1; fd[2*k+1] = ((v[k] >> 8) & 15) | ($urandom_range(0, 15) << 4);
    end
    for (int i = 0; i < 8; i++) x = x ^ fd[i];
    fa[8] = 8; fd[8] = x ^ 'hA5;
    fn = 9;
  endtask

  // start_mode: 0 none, 1 separate start cycle, 2 start with first byte.
  task automatic send(input int start_mode, input bit end_tick, input bit rnd_tick);
    if (start_mode == 1) step(1, 0, 0, 0, 0, rnd_tick && ($urandom_range(0, 3) == 0));
    for (int i = 0; i < fn; i++)
      step((start_mode == 2) && (i == 0), 0, 1, fa[i], fd[i], rnd_tick && ($urandom_range(0, 3) == 0));
    step(0, 1, 0, 0, 0, end_tick);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 1);
  endtask

  task automatic reset_now();
    #2 rst = 1;
    #1;
    model_reset();
    compare_all();
    @(negedge clk);
    rst = 0;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int t;
    model_reset();
    repeat (2) @(negedge clk);
    compare_all();
    chk("reset_safe", int'(safe_stop), 1);
    rst = 0;

    // Valid frame from the worked example.
    fn = 9;
    fa[0]=0; fd[0]='h10; fa[1]=1; fd[1]='h01; fa[2]=2; fd[2]='h20; fa[3]=3; fd[3]='h02;
    fa[4]=4; fd[4]='h30; fa[5]=5; fd[5]='h03; fa[6]=6; fd[6]='h40; fa[7]=7; fd[7]='h84;
    t = 0;
    for (int i = 0; i < 8; i++) t = t ^ fd[i];
    fa[8] = 8; fd[8] = t ^ 'hA5;
    send(1, 0, 0);
    chk("ex_vel0", int'(vel0), 'h110);
    chk("ex_vel1", int'(vel1), 'h220);
    chk("ex_vel2", int'(vel2), 'h330);
    chk("ex_vel3", int'(vel3), 'h440);
    chk("ex_ok", int'(frame_ok), 1);
    chk("ex_safe", int'(safe_stop), 0);
    step(0, 0, 0, 0, 0, 0);
    chk("ok_one_cycle", int'(frame_ok), 0);

    // Bad checksum, then saturation of the error counter.
    fd[8] = fd[8] ^ 1;
    send(1, 0, 0);
    chk("bad_err", int'(frame_err), 1);
    chk("bad_cnt", int'(err_count), 1);
    chk("bad_vel0", int'(vel0), 'h110);
    for (int i = 0; i < 300; i++) send(1, 0, 0);
    chk("err_sat", int'(err_count), 255);

    // Out-of-order addresses.
    build(1, 2, 3, 4);
    fa[2] = 3; fd[2] = fd[3]; fa[3] = 2; fd[3] = 3;
    send(1, 0, 0);
    chk("order_err", int'(frame_err), 1);
    // Truncated frame.
    build(5, 6, 7, 8); fn = 5;
    send(1, 0, 0);
    chk("short_err", int'(frame_err), 1);
    // Aborted partial frame followed by a full one (start coincident with first byte).
    build(9, 9, 9, 9); fn = 4;
    step(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < fn; i++) step(0, 0, 1, fa[i], fd[i], 0);
    build(-7, 300, -1, 2047);
    send(2, 0, 0);
    chk("abort_ok", int'(frame_ok), 1);
    chk("abort_vel3", int'($signed(vel3)), 2047);

    // Watchdog expiry and ramp.
    build(40, -40, 10, -2048);
    send(1, 0, 0);
    ticks(199);
    chk("wdt_199", int'(safe_stop), 0);
    ticks(1);
    chk("wdt_200", int'(safe_stop), 1);
    ticks(8);
    chk("ramp_v0", int'($signed(vel0)), 8);
    chk("ramp_v1", int'($signed(vel1)), -8);
    chk("ramp_v2", int'($signed(vel2)), 0);
    chk("ramp_v3", int'($signed(vel3)), -2016);
    ticks(1);
    // Commit coincident with a ramp tick; the pointer stays at channel 1.
    build(100, 200, -300, 5);
    send(1, 1, 0);
    chk("coinc_v0", int'($signed(vel0)), 100);
    chk("coinc_safe", int'(safe_stop), 0);
    ticks(201);
    chk("p_kept_v1", int'($signed(vel1)), 184);
    chk("p_kept_v0", int'($signed(vel0)), 100);

    // Randomized frames, corruptions and ticks.
    for (int f = 0; f < 40; f++) begin
      build($urandom_range(0, 4095) - 2048, $urandom_range(0, 4095) - 2048,
            $urandom_range(0, 4095) - 2048, $urandom_range(0, 4095) - 2048);
      case ($urandom_range(0, 4))
        1: fd[8] = fd[8] ^ (1 << $urandom_range(0, 7));
        2: begin t = fa[1]; fa[1] = fa[4]; fa[4] = t; end
        3: fn = $urandom_range(0, 8);
        4: for (int j = 0; j < 3; j++) begin fa[fn] = $urandom_range(9, 31); fd[fn] = $urandom_range(0, 255); fn++; end
        default: ;
      endcase
      send($urandom_range(0, 2), $urandom_range(0, 1), 1);
      ticks(($urandom_range(0, 5) == 0) ? $urandom_range(200, 230) : $urandom_range(0, 6));
    end

    // Reset mid-frame, then a frame with no frame_start.
    build(123, -456, 789, -1000);
    send(1, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 1, i, 'h5A, 0);
    reset_now();
    chk("rst_vel1", int'(vel1), 0);
    chk("rst_safe", int'(safe_stop), 1);
    chk("rst_err", int'(err_count), 0);
    build(11, 22, 33, 44);
    send(0, 0, 0);
    chk("post_rst_ok", int'(frame_ok), 1);
    chk("post_rst_v3", int'($signed(vel3)), 44);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/stepgen_cmd_sched.md
# stepgen_cmd_sched

Command scheduler between the SPI byte front end and the four stepgen velocity inputs. Stages the velocity bytes of each SPI frame in shadow registers, validates the frame, and commits all four velocities in one clock when the frame passes. Owns the command watchdog: after a timeout with no valid commit it ramps every channel toward zero velocity, one channel per tick, round-robin.

## Interface
- `F`, 11: velocity fraction width; each velocity is F+1 bits, two's complement, sign at bit F.
- `WDT_W`, 8: watchdog counter width.
- `WDT_LIMIT`, 200: ticks without a valid commit before safe-stop.
- `RAMP`, 16: magnitude reduction applied per scheduled ramp step; width F+1.
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `frame_start`  in  1  one-cycle pulse, SSEL falling edge.
- `frame_end`  in  1  one-cycle pulse, SSEL rising edge.
- `byte_valid`  in  1  one-cycle pulse, received byte available.
- `byte_addr`  in  5  byte index within the frame.
- `byte_data`  in  8  received byte.
- `tick`  in  1  timebase strobe; the stepgen step-count strobe.
- `vel0`..`vel3`  out  F+1 each  committed velocities to stepgen.
- `frame_ok`  out  1  one-cycle pulse, frame committed.
- `frame_err`  out  1  one-cycle pulse, frame rejected.
- `safe_stop`  out  1  level, watchdog expired, ramp active.
- `err_count`  out  8  rejected-frame counter, saturating.

## Operation
- Frame map: addr 2k = lo byte of channel k, 2k+1 = hi byte (k=0..3); addr 8 = checksum; addr 9..31 are ignored and do not affect validity.
- Velocity assembly: {hi[F-8:0], lo}; unused hi bits are ignored.
- Capture state: shadow vel[4], running XOR, next expected addr (0..9), bad flag.
- frame_start clears the capture state: expected=0, XOR=0, bad=0. It aborts any partial frame silently, with no frame_err.
- byte_valid with addr<9:
  - addr≠expected sets bad; otherwise expected increments.
  - addr 0..7 write the shadow register and XOR into the running sum.
  - addr 8 compares byte_data with running XOR ^ 8'hA5; a mismatch sets bad.
- frame_start and byte_valid in the same cycle: the start is applied first, and the byte is processed as the frame's first byte.
- frame_end: the frame is valid iff expected==9 and bad==0.
  - Valid: shadow to vel0..3 on the same edge, frame_ok pulse, watchdog counter=0, safe_stop=0.
  - Invalid: outputs unchanged, frame_err pulse, err_count+1 (saturates at 255).
- Bytes arriving with no frame_start since the last frame_end are processed against the current capture state, which is cleared only by frame_start.
- Watchdog:
  - On each tick while !safe_stop, the counter increments.
  - When the counter equals WDT_LIMIT-1 on a tick, safe_stop sets on that edge and the counter holds.
- Ramp scheduler: 2-bit pointer p, reset 0. On each tick while safe_stop, channel p is updated and p increments (mod 4).
  - If |vel_p| ≤ RAMP, vel_p becomes 0.
  - Else if vel_p > 0, vel_p -= RAMP; else vel_p += RAMP.
  - The most negative value (−2^F) follows the "else" branch, with no overflow.
- Commit and tick in the same cycle: the commit wins, no ramp step is applied, and p is not advanced.
- Reset values:
  - vel0..3 = 0, safe_stop = 1, counter = 0, p = 0.
  - frame_ok = 0, frame_err = 0, err_count = 0.
  - Capture state cleared.

## Timing
- All outputs are registered. An event sampled at edge E is visible in the cycle after E.
- Commit latency: vel and frame_ok change on the edge that samples frame_end. frame_ok/frame_err stay high exactly one cycle.
- safe_stop rises on the edge sampling the WDT_LIMIT-th tick since the last commit.
- Ramp: one channel per tick, so a full four-channel pass takes 4 ticks.
- Throughput: byte_valid is accepted every cycle; there is no back-pressure.
- Asynchronous rst mid-frame or mid-ramp forces all reset values immediately, and the partial frame is discarded.

## Test plan
- Valid frame, bytes 0..7 = 10,01,20,02,30,03,40,84 (hex), checksum = XOR^A5 -> vel0=0x110, vel1=0x220, vel2=0x330, vel3=0x440 (hi bit 7 ignored), frame_ok one cycle, safe_stop=0.
- Same frame with checksum ^ 0x01 -> frame_err pulse, err_count=1, vel unchanged. Repeat 300 bad frames -> err_count holds at 255.
- Addresses 0,1,3,2,… -> frame_err. Only 5 bytes before frame_end -> frame_err. frame_start after 4 bytes, then a full valid frame -> a single frame_ok and no frame_err.
- After commit vel0=+40, vel1=−40, vel2=+10, vel3=−2048, issue 200 ticks -> safe_stop=1. Next 8 ticks -> vel0 24→8, vel1 −24→−8, vel2 0→0, vel3 −2032→−2016 (one channel per tick, p order 0..3).
- Valid frame_end coincident with a ramp tick -> new velocities committed, no ramp applied, safe_stop=0, counter=0, p unchanged.
- Assert rst mid-frame with vel nonzero -> vel=0, safe_stop=1, err_count=0. Subsequent bytes without frame_start plus frame_end -> frame is judged from the cleared state.
